id_decode: RTL and testbench
============================

# id_decode

Registered instruction decode stage for the RV32 core, sitting between fetch and the EX stage. It accepts a 32-bit instruction plus PC over a valid/ready handshake. It produces the EX control bundle in one pipeline register with its own valid/ready handshake: ALU opcode, rs2/immediate select, sign-extended immediate, register addresses and write enable. It is the producer of the `alu_op`/`alu_rs2_imm`/`imm` encoding that EX consumes.

## Interface
- `XLEN`, 32: data/instruction/PC width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  discard the held entry and the incoming entry this cycle
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  raw instruction
- `in_pc`  in  32  instruction PC
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  EX accepts the bundle
- `out_pc`  out  32  PC of the decoded instruction
- `alu_op`  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor
- `alu_rs2_imm`  out  1  1 selects `imm`, 0 selects rs2 data
- `imm`  out  32  sign-extended I-immediate, or U-immediate (`instr[31:12]<<12`)
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  register indices
- `reg_write`  out  1  write `rd_addr` at writeback; forced 0 when `rd_addr`==0
- `illegal`  out  1  unsupported encoding (see Configuration)

## Operation
- Decode table:
  - OP-IMM (0010011):
    - funct3 000 → `alu_op` 0.
    - funct3 100 → 4.
    - funct3 110 → 3.
    - funct3 111 → 2.
    - All four: `alu_rs2_imm`=1, `imm`=sext(`instr[31:20]`).
  - OP (0110011) with funct7 0x00:
    - funct3 000 → 0.
    - funct3 100 → 4.
    - funct3 110 → 3.
    - funct3 111 → 2.
  - OP with funct7 0x20 and funct3 000 → 1 (sub).
  - All OP forms: `alu_rs2_imm`=0, `imm`=0.
  - LUI (0110111): `alu_op` 0, `alu_rs2_imm`=1, `rs1_addr` forced 0, `imm`={`instr[31:12]`,12'b0}.
  - Anything else: unsupported → NOP bundle: `alu_op` 0, `alu_rs2_imm` 0, `imm` 0, `reg_write` 0.
- Address fields come from `instr[19:15]`, `[24:20]`, `[11:7]` for every instruction. The LUI rs1 override is the only exception.
- Single-entry output register: `in_ready` = !`out_valid` | `out_ready` (combinational).
- Load when `in_valid` & `in_ready`: capture the decoded bundle and `in_pc`; `out_valid` ← 1.
- When `out_valid` & `out_ready` and no load: `out_valid` ← 0. Bundle fields hold their last values.
- `flush` has priority over load: `out_valid` ← 0 and the input is dropped. `in_ready` may still read 1 during flush.
- `rst` has priority over `flush`.

## Timing
- Latency: accepted at edge N → visible on outputs after edge N; consumable in cycle N+1.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Reset values: `out_valid` 0, `out_pc` 0, `alu_op` 0, `alu_rs2_imm` 0, `imm` 0, all addresses 0, `reg_write` 0, `illegal` 0.
- Reset mid-stall drops the held entry; `in_ready` reads 1 in the first cycle after reset.
- Accept and drain in the same cycle: new bundle replaces old; `out_valid` stays 1.

## Configuration
- `ID_ILLEGAL_CHK_EN` defined:
  - `illegal` is registered alongside the bundle.
  - It is 1 for an unsupported opcode, an unsupported funct3/funct7 combination, or `instr[1:0]`≠2'b11.
  - An illegal bundle is still a NOP bundle with `reg_write`=0.
- Not defined: `illegal` is tied to 0; unsupported encodings produce the NOP bundle silently.

## Test plan
- After reset, `in_valid`=1, `in_instr`=0x00500093 (addi x1,x0,5) → next cycle: `out_valid` 1, `alu_op` 0, `alu_rs2_imm` 1, `imm` 5, `rs1_addr` 0, `rd_addr` 1, `reg_write` 1.
- 0x402081B3 (sub x3,x1,x2) → `alu_op` 1, `alu_rs2_imm` 0, `rs1_addr` 1, `rs2_addr` 2, `rd_addr` 3.
- 0xFFF34293 (xori x5,x6,-1) → `alu_op` 4, `imm` 0xFFFFFFFF. Then 0x123453B7 (lui x7) → `imm` 0x12345000, `rs1_addr` 0, `alu_op` 0.
- Hold `out_ready`=0 for 3 cycles with a new instruction pending → `in_ready` 0, outputs unchanged. Raise `out_ready` → the next bundle appears one cycle later with no loss or duplication.
- Assert `flush` with `in_valid`=1 and an entry held → next cycle `out_valid` 0; the flushed instruction never appears.
- 0x00000000: with `ID_ILLEGAL_CHK_EN`, `illegal` 1 and `reg_write` 0. Without it, `illegal` 0 and `reg_write` 0.

Source files
------------

// File: rtl/id_decode.sv
// id_decode: RV32 decode stage turning a fetched instruction + PC into the EX control bundle.
// Latency: one cycle; a bundle accepted at edge N is presented on the outputs right after edge N.
// Backpressure: single-entry output register, in_ready = !out_valid | out_ready (combinational).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               drops the held bundle and the instruction offered this cycle
//   in_valid/in_ready   fetch handshake carrying in_instr (32b) and in_pc (XLEN)
//   out_valid/out_ready EX handshake carrying out_pc, alu_op, alu_rs2_imm, imm,
//                       rs1_addr, rs2_addr, rd_addr, reg_write, illegal
//
// Optional feature: define ID_ILLEGAL_CHK_EN to register an 'illegal' flag with each
// bundle; otherwise 'illegal' is constant 0 and unsupported encodings decode silently
// to the NOP bundle.
module id_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_op,
  output logic            alu_rs2_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            illegal
);

  // Major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // ALU operation encoding consumed by EX.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  // Everything registered alongside the PC, packed so reset/load is one assignment.
  typedef struct packed {
    logic [3:0]      alu_op;
    logic            rs2_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // The funct3 -> ALU mapping is shared by OP-IMM and OP (funct7 = 0).
  logic [3:0] f3_alu_op;
  logic       f3_ok;

  always_comb begin
    f3_alu_op = ALU_ADD;
    f3_ok     = 1'b1;
    case (funct3)
      3'b000:  f3_alu_op = ALU_ADD;
      3'b100:  f3_alu_op = ALU_XOR;
      3'b110:  f3_alu_op = ALU_OR;
      3'b111:  f3_alu_op = ALU_AND;
      default: f3_ok     = 1'b0;
    endcase
  end

  ctrl_t dec;
  logic  supported;

  always_comb begin
    // Unsupported encodings fall through as the all-zero NOP bundle, but the register
    // address fields are still passed straight from the instruction.
    dec       = '0;
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    dec.rd    = in_instr[11:7];
    supported = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        if (f3_ok) begin
          supported   = 1'b1;
          dec.alu_op  = f3_alu_op;
          dec.rs2_imm = 1'b1;
          dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_OP: begin
        if (funct7 == 7'h00 && f3_ok) begin
          supported  = 1'b1;
          dec.alu_op = f3_alu_op;
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          supported  = 1'b1;
          dec.alu_op = ALU_SUB;
        end
      end
      OPC_LUI: begin
        // LUI is executed as x0 + imm, so rs1 is forced to x0.
        supported   = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.rs2_imm = 1'b1;
        dec.rs1     = 5'd0;
        dec.imm     = {in_instr[31:12], 12'b0};
      end
      default: ;
    endcase

    // Writes to x0 are suppressed here so writeback never needs to check.
    dec.reg_write = supported && (dec.rd != 5'd0);

`ifdef ID_ILLEGAL_CHK_EN
    // The [1:0] check is implied by the opcode match; kept explicit for readability.
    dec.illegal = !supported || (in_instr[1:0] != 2'b11);
`else
    dec.illegal = 1'b0;
`endif
  end

  ctrl_t ctrl_q;
  logic  load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // Priority: reset, then flush, then load, then drain. Bundle fields only change on
  // load (or reset), so they hold steady through stalls and after draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      ctrl_q    <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op      = ctrl_q.alu_op;
  assign alu_rs2_imm = ctrl_q.rs2_imm;
  assign imm         = ctrl_q.imm;
  assign rs1_addr    = ctrl_q.rs1;
  assign rs2_addr    = ctrl_q.rs2;
  assign rd_addr     = ctrl_q.rd;
  assign reg_write   = ctrl_q.reg_write;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_decode.sv
module tb_id_decode;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [3:0]  alu_op;
  logic        alu_rs2_imm, reg_write, illegal;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  always #5 clk = ~clk;

  id_decode #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_op(alu_op), .alu_rs2_imm(alu_rs2_imm), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .reg_write(reg_write), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic        sel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, ill;
  } bundle_t;

  bundle_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;

  // Reference decode written straight from the decode table with integer arithmetic.
  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t     b;
    int unsigned u, opc, f3, f7, v;
    int          alu;
    bit          ok;
    u   = ins;
    opc = u % 128;
    f3  = (u / 4096) % 8;
    f7  = u / 33554432;
    b.pc  = pc;
    b.rs1 = 5'((u / 32768) % 32);
    b.rs2 = 5'((u / 1048576) % 32);
    b.rd  = 5'((u / 128) % 32);
    b.op  = 4'd0;
    b.sel = 1'b0;
    b.imm = 32'd0;
    ok    = 1'b0;
    alu   = (f3 == 0) ? 0 : (f3 == 4) ? 4 : (f3 == 6) ? 3 : (f3 == 7) ? 2 : -1;
    if (opc == 19 && alu >= 0) begin
      ok = 1'b1; b.op = 4'(alu); b.sel = 1'b1;
      v = u / 1048576;
      b.imm = (v >= 2048) ? 32'(v) - 32'd4096 : 32'(v);
    end else if (opc == 51 && f7 == 0 && alu >= 0) begin
      ok = 1'b1; b.op = 4'(alu);
    end else if (opc == 51 && f7 == 32 && f3 == 0) begin
      ok = 1'b1; b.op = 4'd1;
    end else if (opc == 55) begin
      ok = 1'b1; b.sel = 1'b1; b.rs1 = 5'd0;
      b.imm = 32'((u / 4096) * 4096);
    end
    b.rw = ok && (b.rd != 5'd0);
`ifdef ID_ILLEGAL_CHK_EN
    b.ill = !ok;
`else
    b.ill = 1'b0;
`endif
    return b;
  endfunction

  function automatic bundle_t got_bundle();
    bundle_t g;
    g.pc = out_pc; g.op = alu_op; g.sel = alu_rs2_imm; g.imm = imm;
    g.rs1 = rs1_addr; g.rs2 = rs2_addr; g.rd = rd_addr; g.rw = reg_write; g.ill = illegal;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: compares the presented bundle against the scoreboard head every cycle it is
  // valid (so stalls must hold it steady) and retires it on a real handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (in_ready !== (exp_q.size() == 0 || out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b", in_ready, (exp_q.size() == 0 || out_ready));
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b", out_valid, (exp_q.size() != 0));
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if (got_bundle() !== exp_q[0]) begin
          errors++;
          $display("FAIL bundle: got %h expected %h", got_bundle(), exp_q[0]);
        end
        if (out_ready && !flush && !rst) void'(exp_q.pop_front());
      end
    end
  end

  // Advance one cycle: after the monitor, record what the coming edge will capture,
  // then return just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    @(negedge clk);
    #1;
    if (rst || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_ill;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_fields", {15'd0, alu_op, alu_rs2_imm, rs1_addr, rs2_addr, rd_addr, reg_write, illegal},
        32'd0);

    // Directed decode, back-to-back with EX always ready
    out_ready = 1'b1;
    send(32'h00500093, 32'h100);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_op", {28'd0, alu_op}, 32'd0);
    chk("addi_sel", {31'd0, alu_rs2_imm}, 32'd1);
    chk("addi_imm", imm, 32'd5);
    chk("addi_rs1", {27'd0, rs1_addr}, 32'd0);
    chk("addi_rd", {27'd0, rd_addr}, 32'd1);
    chk("addi_rw", {31'd0, reg_write}, 32'd1);
    send(32'h402081B3, 32'h104);
    chk("sub_op", {28'd0, alu_op}, 32'd1);
    chk("sub_sel", {31'd0, alu_rs2_imm}, 32'd0);
    chk("sub_regs", {17'd0, rs1_addr, rs2_addr, rd_addr}, {17'd0, 5'd1, 5'd2, 5'd3});
    send(32'hFFF34293, 32'h108);
    chk("xori_op", {28'd0, alu_op}, 32'd4);
    chk("xori_imm", imm, 32'hFFFFFFFF);
    send(32'h123453B7, 32'h10C);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rs1", {27'd0, rs1_addr}, 32'd0);
    chk("lui_op", {28'd0, alu_op}, 32'd0);
    send(32'h00000000, 32'h110);
`ifdef ID_ILLEGAL_CHK_EN
    exp_ill = 32'd1;
`else
    exp_ill = 32'd0;
`endif
    chk("zero_illegal", {31'd0, illegal}, exp_ill);
    chk("zero_rw", {31'd0, reg_write}, 32'd0);
    tick();

    // Stall: hold EX off while a second instruction waits
    out_ready = 1'b0;
    send(32'h00100093, 32'h200);
    in_valid = 1'b1; in_instr = 32'h00208133; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_pc", out_pc, 32'h200);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("unstall_pc", out_pc, 32'h204);
    chk("unstall_valid", {31'd0, out_valid}, 32'd1);
    tick();
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Flush with an entry held and another offered
    out_ready = 1'b0;
    send(32'h00300193, 32'h300);
    in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'h304; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("flush_no_replay", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h00500293, 32'h400);
    in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h404; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_pc", out_pc, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] r;
      int unsigned kind;
      r    = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0: in_instr = {r[31:7], 7'b0010011};
        1: in_instr = {7'h00, r[24:7], 7'b0110011};
        2: in_instr = {7'h20, r[24:7], 7'b0110011};
        3: in_instr = {r[31:7], 7'b0110111};
        4: in_instr = {r[31:2], 2'($urandom_range(0, 2))};
        default: in_instr = r;
      endcase
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
